// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types and helpers.
//   cbus_req_t  : request from a cache-side master toward memory
//   cbus_resp_t : response/acceptance from memory back to a master
//   idx_width() : index width for an N-entry selector, never below 1 bit
package cbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;      // beats in the transaction
        logic [31:0] data;
        logic [3:0]  strobe;
        logic        last;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;    // beat accepted (write) or returned (read)
        logic        last;     // final beat of the transaction
        logic [31:0] data;
    } cbus_resp_t;

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_picker.sv
// Combinational round-robin picker.
//   valid : per-requester request bits
//   ptr   : index to start scanning from (must be < N)
//   found : at least one requester is valid
//   index : first valid index at or above ptr, wrapping modulo N
module cbus_rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        int j;
        found = 1'b0;
        index = '0;
        j     = 0;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (valid[j]) begin
                found = 1'b1;
                index = W'(j);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS cache-bus masters onto one
// memory-side port. A master is granted for a whole transaction; the grant
// is released on the beat where the memory reports ready && last.
//   clk, resetn : clock, asynchronous active-low reset
//   ireqs       : per-master requests (index 0 = data cache)
//   iresps      : per-master responses (only the granted one is non-zero)
//   oreq        : request forwarded to memory
//   oresp       : response from memory
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int W = idx_width(NUM_INPUTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [W-1:0]    grant_idx;
    logic [W-1:0]    rr_ptr;
    logic [W-1:0]    next_ptr;
    logic [NUM_INPUTS-1:0] req_valid;
    logic            pick_found;
    logic [W-1:0]    pick_idx;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
    end

    cbus_rr_picker #(.N(NUM_INPUTS), .W(W)) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign next_ptr = (grant_idx == W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;

    // The grant only moves from IDLE, so oresp never feeds the picker; the
    // IDLE cycle after a release is the one-cycle bubble between owners.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant_idx <= pick_idx;
                    state     <= BUSY;
                end
                BUSY: if (oresp.ready && oresp.last) begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Transparent forwarding while busy; a dropped valid mid-burst is
    // forwarded as-is and the grant is still held until last.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
        if (state == BUSY) begin
            oreq              = ireqs[grant_idx];
            iresps[grant_idx] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  req    [3];
    cbus_req_t  req2   [2];
    cbus_resp_t oresp;
    cbus_resp_t iresps2 [2];
    cbus_resp_t iresps3 [3];
    cbus_req_t  oreq2, oreq3;

    always #5 clk = ~clk;

    always_comb begin
        req2[0] = req[0];
        req2[1] = req[1];
    end

    cbus_arbiter #(.NUM_INPUTS(2)) dut2 (
        .clk(clk), .resetn(resetn), .ireqs(req2), .iresps(iresps2), .oreq(oreq2), .oresp(oresp));
    cbus_arbiter #(.NUM_INPUTS(3)) dut3 (
        .clk(clk), .resetn(resetn), .ireqs(req), .iresps(iresps3), .oreq(oreq3), .oresp(oresp));

    int checks = 0, errors = 0;
    int n = 2;             // which DUT is under test (2 or 3 masters)
    int cyc = 0;
    int txn = 0;
    // reference model: who owns the bus and where rotation starts next
    bit m_busy;
    int m_grant, m_rr, beat;
    // master / memory behaviour
    bit mpend [3];
    int auto_len [3];
    bit rnd_ready = 0, junk = 0;
    // observations
    bit prev_valid;
    int rdy_cnt [3];
    int done_cnt;
    int glog[$], gcyc[$], fcyc[$];

    function automatic cbus_req_t act_oreq();
        return (n == 3) ? oreq3 : oreq2;
    endfunction

    function automatic cbus_resp_t act_iresp(int i);
        if (n == 3) return iresps3[i];
        if (i < 2) return iresps2[i];
        return '0;
    endfunction

    task automatic start_req(int m, int len, bit wr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = 32'((m << 8) | (txn & 255));
        r.size     = 3'd2;
        r.len      = 8'(len);
        r.data     = $urandom;
        r.strobe   = 4'hf;
        req[m]     = r;
        mpend[m]   = 1'b1;
        txn++;
    endtask

    task automatic do_reset(int nn);
        resetn = 1'b0;
        n = nn;
        for (int m = 0; m < 3; m++) begin
            req[m] = '0; mpend[m] = 0; auto_len[m] = 0; rdy_cnt[m] = 0;
        end
        oresp = '0;
        m_busy = 0; m_grant = 0; m_rr = 0; beat = 0;
        prev_valid = 0; done_cnt = 0;
        glog.delete(); gcyc.delete(); fcyc.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One clock: drive memory, check outputs against the model, advance.
    task automatic step();
        cbus_req_t eo, ao;
        cbus_resp_t er, ar;
        bit fin;
        int pick;
        if (m_busy) begin
            oresp.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            oresp.last  = oresp.ready && (beat == int'(req[m_grant].len) - 1);
            oresp.data  = $urandom;
        end else if (junk) begin
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = 1'($urandom_range(0, 1));
            oresp.data  = $urandom;
        end else begin
            oresp = '0;
        end
        #1;
        eo = m_busy ? req[m_grant] : '0;
        ao = act_oreq();
        checks++;
        if (ao !== eo) begin
            errors++;
            $display("FAIL oreq cyc=%0d got=%h exp=%h", cyc, ao, eo);
        end
        for (int i = 0; i < n; i++) begin
            er = (m_busy && i == m_grant) ? oresp : '0;
            ar = act_iresp(i);
            checks++;
            if (ar !== er) begin
                errors++;
                $display("FAIL iresp%0d cyc=%0d got=%h exp=%h", i, cyc, ar, er);
            end
            rdy_cnt[i] += int'(ar.ready);
        end
        if (ao.valid && !prev_valid) begin
            glog.push_back(int'(ao.addr[15:8]));
            gcyc.push_back(cyc);
        end
        prev_valid = ao.valid;
        fin  = m_busy && oresp.ready && oresp.last;
        pick = -1;
        if (!m_busy)
            for (int k = 0; k < n; k++)
                if (pick < 0 && req[(m_rr + k) % n].valid) pick = (m_rr + k) % n;
        @(posedge clk);
        #1;
        if (fin) begin
            m_busy = 0;
            m_rr = (m_grant + 1) % n;
            mpend[m_grant] = 0;
            req[m_grant] = '0;
            done_cnt++;
            fcyc.push_back(cyc);
            beat = 0;
        end else if (m_busy && oresp.ready) begin
            beat++;
        end else if (pick >= 0) begin
            m_busy = 1; m_grant = pick; beat = 0;
        end
        cyc++;
        @(negedge clk);
        for (int m = 0; m < n; m++)
            if (!mpend[m] && auto_len[m] > 0) start_req(m, auto_len[m], 1'b0);
    endtask

    task automatic run_txns(int target, int budget, string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin step(); k++; end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout done=%0d want=%0d", name, done_cnt, target);
        end
    endtask

    task automatic drain(int budget, string name);
        int k = 0;
        while ((m_busy || mpend[0] || mpend[1] || mpend[2]) && k < budget) begin step(); k++; end
        checks++;
        if (m_busy || mpend[0] || mpend[1] || mpend[2]) begin
            errors++;
            $display("FAIL %s drain timeout", name);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        n = 2;
        for (int m = 0; m < 3; m++) start_req(m, 4, 1'b0);
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hdeadbeef};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oreq2 !== '0) begin errors++; $display("FAIL reset_oreq2 got=%h exp=0", oreq2); end
        checks++; if (oreq3 !== '0) begin errors++; $display("FAIL reset_oreq3 got=%h exp=0", oreq3); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (iresps2[i] !== '0) begin errors++; $display("FAIL reset_iresp2_%0d got=%h exp=0", i, iresps2[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iresps3[i] !== '0) begin errors++; $display("FAIL reset_iresp3_%0d got=%h exp=0", i, iresps3[i]); end
        end
        @(negedge clk);
        do_reset(2);
    endtask

    task automatic test_single();
        int s;
        do_reset(2);
        s = cyc;
        start_req(0, 4, 1'b0);
        run_txns(1, 20, "single");
        step();
        checks++; if (gcyc.size() < 1 || gcyc[0] != s + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", gcyc.size() ? gcyc[0] : -1, s + 1); end
        checks++; if (glog.size() != 1 || glog[0] != 0) begin errors++; $display("FAIL single_owner got=%0d exp=0", glog.size() ? glog[0] : -1); end
        checks++; if (rdy_cnt[0] != 4) begin errors++; $display("FAIL single_beats0 got=%0d exp=4", rdy_cnt[0]); end
        checks++; if (rdy_cnt[1] != 0) begin errors++; $display("FAIL single_beats1 got=%0d exp=0", rdy_cnt[1]); end
        checks++; if (prev_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%0d exp=0", prev_valid); end
    endtask

    task automatic test_simultaneous();
        int exp_ord[4] = '{0, 1, 0, 1};
        do_reset(2);
        start_req(0, 3, 1'b0);
        start_req(1, 2, 1'b1);
        run_txns(2, 30, "simul");
        checks++;
        if (gcyc.size() < 2 || fcyc.size() < 1 || gcyc[1] != fcyc[0] + 2) begin
            errors++; $display("FAIL simul_second_grant got=%0d exp=%0d", gcyc.size() > 1 ? gcyc[1] : -1, fcyc.size() ? fcyc[0] + 2 : -1);
        end
        // rotation must be back at master 0 after master 1 finishes
        start_req(0, 2, 1'b0);
        start_req(1, 2, 1'b0);
        run_txns(4, 30, "simul2");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (glog.size() <= i || glog[i] != exp_ord[i]) begin
                errors++; $display("FAIL simul_order[%0d] got=%0d exp=%0d", i, glog.size() > i ? glog[i] : -1, exp_ord[i]);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_ord[4] = '{0, 1, 0, 1};
        do_reset(2);
        auto_len[0] = 2;
        auto_len[1] = 3;
        start_req(0, 2, 1'b0);
        start_req(1, 3, 1'b0);
        run_txns(4, 60, "fair");
        auto_len[0] = 0; auto_len[1] = 0;
        drain(40, "fair");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (glog.size() <= i || glog[i] != exp_ord[i]) begin
                errors++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", i, glog.size() > i ? glog[i] : -1, exp_ord[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_ord[4] = '{0, 1, 2, 0};
        do_reset(3);
        for (int m = 0; m < 3; m++) begin auto_len[m] = m + 1; start_req(m, m + 1, 1'b0); end
        run_txns(4, 60, "wrap");
        for (int m = 0; m < 3; m++) auto_len[m] = 0;
        drain(40, "wrap");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (glog.size() <= i || glog[i] != exp_ord[i]) begin
                errors++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", i, glog.size() > i ? glog[i] : -1, exp_ord[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int s;
        do_reset(2);
        start_req(0, 8, 1'b1);
        while (rdy_cnt[0] < 2 && k < 20) begin step(); k++; end
        checks++; if (rdy_cnt[0] != 2) begin errors++; $display("FAIL rmid_beats got=%0d exp=2", rdy_cnt[0]); end
        #2;
        checks++; if (act_oreq().valid !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%0d exp=1", act_oreq().valid); end
        resetn = 1'b0;
        #1;
        checks++; if (act_oreq().valid !== 1'b0) begin errors++; $display("FAIL rmid_async got=%0d exp=0", act_oreq().valid); end
        checks++; if (act_iresp(0) !== '0) begin errors++; $display("FAIL rmid_iresp0 got=%h exp=0", act_iresp(0)); end
        @(negedge clk);
        do_reset(2);
        step();
        step();
        s = cyc;
        start_req(1, 2, 1'b0);
        run_txns(1, 20, "rmid");
        checks++; if (gcyc.size() < 1 || gcyc[0] != s + 1) begin errors++; $display("FAIL rmid_latency got=%0d exp=%0d", gcyc.size() ? gcyc[0] : -1, s + 1); end
        checks++; if (glog.size() < 1 || glog[0] != 1) begin errors++; $display("FAIL rmid_owner got=%0d exp=1", glog.size() ? glog[0] : -1); end
    endtask

    task automatic test_stall();
        do_reset(2);
        rnd_ready = 1;
        start_req(1, 16, 1'b1);
        step();
        step();
        start_req(0, 2, 1'b0);
        run_txns(1, 100, "stall1");
        checks++; if (rdy_cnt[0] != 0) begin errors++; $display("FAIL stall_leak got=%0d exp=0", rdy_cnt[0]); end
        checks++; if (rdy_cnt[1] != 16) begin errors++; $display("FAIL stall_beats1 got=%0d exp=16", rdy_cnt[1]); end
        run_txns(2, 40, "stall2");
        checks++;
        if (gcyc.size() < 2 || fcyc.size() < 1 || gcyc[1] != fcyc[0] + 2) begin
            errors++; $display("FAIL stall_grant got=%0d exp=%0d", gcyc.size() > 1 ? gcyc[1] : -1, fcyc.size() ? fcyc[0] + 2 : -1);
        end
        checks++; if (glog.size() < 2 || glog[1] != 0) begin errors++; $display("FAIL stall_owner got=%0d exp=0", glog.size() > 1 ? glog[1] : -1); end
        rnd_ready = 0;
    endtask

    task automatic test_random(int nn);
        do_reset(nn);
        rnd_ready = 1;
        junk = 1;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < nn; m++)
                if (!mpend[m] && $urandom_range(0, 2) == 0)
                    start_req(m, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
            step();
        end
        drain(300, "random");
        checks++;
        if (glog.size() != done_cnt) begin
            errors++; $display("FAIL random_grants n=%0d got=%0d exp=%0d", nn, glog.size(), done_cnt);
        end
        rnd_ready = 0;
        junk = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_wrap();
        test_reset_mid();
        test_stall();
        test_random(2);
        test_random(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
